// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// request-source encoding and the line-offset helper.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_LINE_SIZE = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // Number of byte-offset bits inside one cache line.
  function automatic int line_off_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the memory-port arbiter.
// slave is the arbiter's view; master is the view of the core and memory model.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LINE_SIZE = DEF_LINE_SIZE
);
  logic                 i_read;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_res;
  logic [WORD_SIZE-1:0] i_res_addr;
  logic [LINE_SIZE-1:0] i_res_data;
  logic                 d_read;
  logic [WORD_SIZE-1:0] d_addr;
  logic                 d_res;
  logic [WORD_SIZE-1:0] d_res_addr;
  logic [LINE_SIZE-1:0] d_res_data;
  logic                 d_wenable;
  logic [WORD_SIZE-1:0] d_w_addr;
  logic [LINE_SIZE-1:0] d_w_data;
  logic                 d_w_full;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_req_addr;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_write_addr;
  logic [LINE_SIZE-1:0] mem_write_data;
  logic                 mem_res;
  logic [WORD_SIZE-1:0] mem_res_addr;
  logic [LINE_SIZE-1:0] mem_res_data;

  modport slave (
    input  i_read, i_addr, d_read, d_addr, d_wenable, d_w_addr, d_w_data,
           mem_res, mem_res_addr, mem_res_data,
    output i_res, i_res_addr, i_res_data, d_res, d_res_addr, d_res_data,
           d_w_full, mem_req, mem_req_addr, mem_write, mem_write_addr,
           mem_write_data
  );

  modport master (
    output i_read, i_addr, d_read, d_addr, d_wenable, d_w_addr, d_w_data,
           mem_res, mem_res_addr, mem_res_data,
    input  i_res, i_res_addr, i_res_data, d_res, d_res_addr, d_res_data,
           d_w_full, mem_req, mem_req_addr, mem_write, mem_write_addr,
           mem_write_data
  );

endinterface

// File: rtl/mem_wb_fifo.sv
// Synchronous posted-write FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. full is registered, empty derives from count.
module mem_wb_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  // A push into a full FIFO is still safe when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);
  assign rdata      = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache refills, D-cache refills and posted
// D-cache line writes, with a single memory read outstanding at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int WB_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int OFF_W = line_off_w(LINE_SIZE);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {WORD_SIZE{1'b1}} << OFF_W;

  function automatic logic [WORD_SIZE-1:0] align(input logic [WORD_SIZE-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  arb_state_t state;
  src_t       rr;
  src_t       rd_src;
  src_t       grant_src;
  logic       i_pend;
  logic       d_pend;
  logic       iss_write;
  logic       resp_hit;
  logic [WORD_SIZE-1:0] i_addr_q;
  logic [WORD_SIZE-1:0] d_addr_q;

  logic                           wb_pop;
  logic                           wb_full;
  logic                           wb_empty;
  logic [CNT_W-1:0]               wb_count;
  logic [WORD_SIZE+LINE_SIZE-1:0] wb_head;

  mem_wb_fifo #(
    .WIDTH (WORD_SIZE + LINE_SIZE),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.d_wenable),
    .pop   (wb_pop),
    .wdata ({align(bus.d_w_addr), bus.d_w_data}),
    .rdata (wb_head),
    .full  (wb_full),
    .empty (wb_empty),
    .count (wb_count)
  );

  assign bus.d_w_full = wb_full;
  assign wb_pop       = (state == ARB_IDLE) && !wb_empty;
  assign resp_hit     = (state == ARB_WAIT) && bus.mem_res &&
                        (align(bus.mem_res_addr) == bus.mem_req_addr);

  // Round-robin only decides a tie; a lone requester wins outright.
  always_comb begin
    grant_src = SRC_I;
    if (i_pend && d_pend) grant_src = rr;
    else if (d_pend)      grant_src = SRC_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ARB_IDLE;
      rr                 <= SRC_I;
      rd_src             <= SRC_I;
      i_pend             <= 1'b0;
      d_pend             <= 1'b0;
      iss_write          <= 1'b0;
      i_addr_q           <= '0;
      d_addr_q           <= '0;
      bus.i_res          <= 1'b0;
      bus.i_res_addr     <= '0;
      bus.i_res_data     <= '0;
      bus.d_res          <= 1'b0;
      bus.d_res_addr     <= '0;
      bus.d_res_data     <= '0;
      bus.mem_req        <= 1'b0;
      bus.mem_req_addr   <= '0;
      bus.mem_write      <= 1'b0;
      bus.mem_write_addr <= '0;
      bus.mem_write_data <= '0;
    end else begin
      bus.i_res     <= 1'b0;
      bus.d_res     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_write <= 1'b0;

      if (bus.i_read && !i_pend) begin
        i_pend   <= 1'b1;
        i_addr_q <= align(bus.i_addr);
      end
      if (bus.d_read && !d_pend) begin
        d_pend   <= 1'b1;
        d_addr_q <= align(bus.d_addr);
      end

      case (state)
        ARB_IDLE: begin
          // Posted writes drain first so a later D-read sees memory up to date.
          if (wb_count != '0) begin
            bus.mem_write      <= 1'b1;
            bus.mem_write_addr <= wb_head[WORD_SIZE+LINE_SIZE-1:LINE_SIZE];
            bus.mem_write_data <= wb_head[LINE_SIZE-1:0];
            iss_write          <= 1'b1;
            state              <= ARB_ISSUE;
          end else if (i_pend || d_pend) begin
            bus.mem_req      <= 1'b1;
            bus.mem_req_addr <= (grant_src == SRC_I) ? i_addr_q : d_addr_q;
            rd_src           <= grant_src;
            iss_write        <= 1'b0;
            state            <= ARB_ISSUE;
            if (i_pend && d_pend) rr <= (rr == SRC_I) ? SRC_D : SRC_I;
          end
        end
        ARB_ISSUE: state <= iss_write ? ARB_IDLE : ARB_WAIT;
        ARB_WAIT: begin
          if (resp_hit) begin
            if (rd_src == SRC_I) begin
              bus.i_res      <= 1'b1;
              bus.i_res_addr <= align(bus.mem_res_addr);
              bus.i_res_data <= bus.mem_res_data;
              i_pend         <= 1'b0;
            end else begin
              bus.d_res      <= 1'b1;
              bus.d_res_addr <= align(bus.mem_res_addr);
              bus.d_res_data <= bus.mem_res_data;
              d_pend         <= 1'b0;
            end
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: hand-written cycle sequences plus a vector table,
// with a response-latency memory model and per-path expectation queues.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int WS = 32;
  localparam int LS = 128;
  localparam int RESP_LAT = 3;
  localparam int NV = 8;
  localparam logic [31:0] AMASK = 32'hFFFF_FFF0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } log_t;

  typedef struct packed {
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic [31:0]  da;
    logic         dw;
    logic [31:0]  wa;
    logic [127:0] wd;
    logic [1:0]   n;
    log_t [2:0]   ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORD_SIZE(WS), .LINE_SIZE(LS)) bus ();

  mem_port_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .WB_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic auto_mem;
  int resp_cnt;
  logic [31:0] resp_addr;
  logic [31:0]  i_q[$];
  logic [31:0]  d_q[$];
  logic [31:0]  w_addr_q[$];
  logic [127:0] w_data_q[$];
  log_t         log_q[$];
  vec_t         vecs[NV];

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    return {a, ~a, a + 32'h1111_1111, a ^ 32'hA5A5_A5A5};
  endfunction

  function automatic log_t lr(input logic [31:0] a);
    return {1'b0, a};
  endfunction

  function automatic log_t lw(input logic [31:0] a);
    return {1'b1, a};
  endfunction

  function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                              input logic dr, input logic [31:0] da,
                              input logic dw, input logic [31:0] wa,
                              input logic [127:0] wd, input logic [1:0] n,
                              input log_t e0, input log_t e1, input log_t e2);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
    v.dw = dw; v.wa = wa; v.wd = wd; v.n = n;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkst(input string name, input arb_state_t act, input arb_state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got a pulse, want none", name);
  endtask

  task automatic monitor();
    logic [31:0] ea;
    if (bus.mem_req) begin
      log_q.push_back(lr(bus.mem_req_addr));
      if (auto_mem) begin
        resp_cnt  = RESP_LAT;
        resp_addr = bus.mem_req_addr;
      end
    end
    if (bus.mem_write) begin
      log_q.push_back(lw(bus.mem_write_addr));
      if (w_addr_q.size() == 0) unexpected("mem_write");
      else begin
        chk32("mem_write_addr", bus.mem_write_addr, w_addr_q.pop_front());
        chk128("mem_write_data", bus.mem_write_data, w_data_q.pop_front());
      end
    end
    if (bus.i_res) begin
      if (i_q.size() == 0) unexpected("i_res");
      else begin
        ea = i_q.pop_front();
        chk32("i_res_addr", bus.i_res_addr, ea);
        chk128("i_res_data", bus.i_res_data, mem_line(ea));
      end
    end
    if (bus.d_res) begin
      if (d_q.size() == 0) unexpected("d_res");
      else begin
        ea = d_q.pop_front();
        chk32("d_res_addr", bus.d_res_addr, ea);
        chk128("d_res_data", bus.d_res_data, mem_line(ea));
      end
    end
  endtask

  // One cycle: sample at the falling edge, retire pulses, run the memory model.
  task automatic tick();
    @(negedge clk);
    monitor();
    bus.i_read    = 1'b0;
    bus.d_read    = 1'b0;
    bus.d_wenable = 1'b0;
    bus.mem_res   = 1'b0;
    if (auto_mem && resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.mem_res      = 1'b1;
        bus.mem_res_addr = resp_addr;
        bus.mem_res_data = mem_line(resp_addr);
      end
    end
  endtask

  task automatic req_i(input logic [31:0] a);
    chk1("proto_i_read_while_pending", dut.i_pend, 1'b0);
    bus.i_read = 1'b1;
    bus.i_addr = a;
    i_q.push_back(a & AMASK);
  endtask

  task automatic req_d(input logic [31:0] a);
    chk1("proto_d_read_while_pending", dut.d_pend, 1'b0);
    bus.d_read = 1'b1;
    bus.d_addr = a;
    d_q.push_back(a & AMASK);
  endtask

  task automatic wr_d(input logic [31:0] a, input logic [127:0] d);
    chk1("proto_d_wenable_while_full", bus.d_w_full, 1'b0);
    bus.d_wenable = 1'b1;
    bus.d_w_addr  = a;
    bus.d_w_data  = d;
    w_addr_q.push_back(a & AMASK);
    w_data_q.push_back(d);
  endtask

  task automatic drive_res(input logic [31:0] a);
    bus.mem_res      = 1'b1;
    bus.mem_res_addr = a;
    bus.mem_res_data = mem_line(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || w_addr_q.size() != 0 || resp_cnt != 0)
           && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idle timeout i_q=%0d d_q=%0d w_q=%0d", i_q.size(), d_q.size(),
               w_addr_q.size());
    end
    tick();
    tick();
  endtask

  task automatic chk_log(input string name, input int n, input log_t e0, input log_t e1,
                         input log_t e2);
    log_t ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    chk32({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < log_q.size()) begin
        chk1($sformatf("%s_%0d_wr", name, k), log_q[k].wr, ex[k].wr);
        chk32($sformatf("%s_%0d_addr", name, k), log_q[k].addr, ex[k].addr);
      end
    end
  endtask

  initial begin
    vecs[0] = mk(1, 32'h0000_1234, 0, 0, 0, 0, 0, 1, lr(32'h1230), '0, '0);
    vecs[1] = mk(0, 0, 1, 32'h0000_5678, 0, 0, 0, 1, lr(32'h5670), '0, '0);
    vecs[2] = mk(1, 32'h0000_A008, 1, 32'h0000_B00C, 0, 0, 0, 2,
                 lr(32'hA000), lr(32'hB000), '0);
    vecs[3] = mk(1, 32'h0000_C004, 1, 32'h0000_D008, 1, 32'h0000_E00F,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3,
                 lw(32'hE000), lr(32'hD000), lr(32'hC000));
    vecs[4] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, {128{1'b1}}, 1, lw(32'hFFFF_FFF0), '0, '0);
    vecs[5] = mk(1, 32'h0000_0010, 1, 32'h0000_0020, 0, 0, 0, 2,
                 lr(32'h0010), lr(32'h0020), '0);
    vecs[6] = mk(1, 32'h0000_7777, 0, 0, 1, 32'h0000_8888, {4{32'h1357_9BDF}}, 2,
                 lw(32'h8880), lr(32'h7770), '0);
    vecs[7] = mk(0, 0, 1, 32'h0000_2004, 1, 32'h0000_2000, {4{32'h0F0F_0F0F}}, 2,
                 lw(32'h2000), lr(32'h2000), '0);

    rst = 1'b1;
    auto_mem = 1'b0;
    resp_cnt = 0;
    resp_addr = '0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_addr = '0;
    bus.d_wenable = 1'b0; bus.d_w_addr = '0; bus.d_w_data = '0;
    bus.mem_res = 1'b0; bus.mem_res_addr = '0; bus.mem_res_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk1("rst_i_res", bus.i_res, 1'b0);
    chk1("rst_d_res", bus.d_res, 1'b0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk1("rst_d_w_full", bus.d_w_full, 1'b0);
    chk32("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    chk128("rst_i_res_data", bus.i_res_data, 128'h0);
    chkst("rst_state", dut.state, ARB_IDLE);

    // Single I miss with exact cycle timing.
    log_q.delete();
    req_i(32'h0000_1004);
    tick();
    chk1("imiss_c1_mem_req", bus.mem_req, 1'b0);
    tick();
    chk1("imiss_c2_mem_req", bus.mem_req, 1'b1);
    chk32("imiss_c2_addr", bus.mem_req_addr, 32'h0000_1000);
    tick();
    chk1("imiss_c3_mem_req", bus.mem_req, 1'b0);
    tick();
    tick();
    chk1("imiss_c5_i_res", bus.i_res, 1'b0);
    drive_res(32'h0000_1000);
    tick();
    chk1("imiss_c6_i_res", bus.i_res, 1'b1);
    chk1("imiss_c6_d_res", bus.d_res, 1'b0);
    chk32("imiss_c6_i_res_addr", bus.i_res_addr, 32'h0000_1000);
    wait_idle();

    // Contention twice: the tie goes to I first, then to D.
    auto_mem = 1'b1;
    log_q.delete();
    req_i(32'h0000_0100);
    req_d(32'h0000_0200);
    wait_idle();
    chk_log("rr1", 2, lr(32'h0100), lr(32'h0200), '0);
    log_q.delete();
    req_i(32'h0000_0100);
    req_d(32'h0000_0200);
    wait_idle();
    chk_log("rr2", 2, lr(32'h0200), lr(32'h0100), '0);

    // Write takes priority over a D-read to the same line.
    log_q.delete();
    req_d(32'h0000_2000);
    wr_d(32'h0000_2000, {4{32'hA5A5_A5A5}});
    wait_idle();
    chk_log("wprio", 2, lw(32'h2000), lr(32'h2000), '0);

    // Fill the FIFO while a read is stuck in WAIT, then let it drain.
    auto_mem = 1'b0;
    log_q.delete();
    req_i(32'h0000_9000);
    tick();
    tick();
    tick();
    wr_d(32'h0000_9100, {4{32'h1111_2222}});
    tick();
    chk1("full_after_one", bus.d_w_full, 1'b0);
    wr_d(32'h0000_9200, {4{32'h3333_4444}});
    tick();
    chk1("full_after_two", bus.d_w_full, 1'b1);
    chk1("full_no_drain", bus.mem_write, 1'b0);
    drive_res(32'h0000_9000);
    tick();
    chk1("full_resp_cycle", bus.d_w_full, 1'b1);
    tick();
    chk1("full_after_pop", bus.d_w_full, 1'b0);
    chk1("full_pop_write", bus.mem_write, 1'b1);
    wait_idle();
    chk_log("fifo", 3, lr(32'h9000), lw(32'h9100), lw(32'h9200));

    // Mismatched response is dropped; the matching one completes the read.
    req_d(32'h0000_3008);
    tick();
    tick();
    chk32("mm_req_addr", bus.mem_req_addr, 32'h0000_3000);
    tick();
    drive_res(32'h0000_4000);
    tick();
    chk1("mm_no_d_res", bus.d_res, 1'b0);
    chk1("mm_no_i_res", bus.i_res, 1'b0);
    chkst("mm_state_wait", dut.state, ARB_WAIT);
    tick();
    tick();
    chkst("mm_state_still_wait", dut.state, ARB_WAIT);
    drive_res(32'h0000_3000);
    tick();
    chk1("mm_d_res", bus.d_res, 1'b1);
    chk32("mm_d_res_addr", bus.d_res_addr, 32'h0000_3000);
    wait_idle();

    // Reset while waiting: the stale response must be ignored.
    req_i(32'h0000_5000);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_q.delete(); d_q.delete(); w_addr_q.delete(); w_data_q.delete(); log_q.delete();
    resp_cnt = 0;
    drive_res(32'h0000_5000);
    tick();
    chk1("rstw_i_res", bus.i_res, 1'b0);
    chk1("rstw_d_res", bus.d_res, 1'b0);
    chk1("rstw_i_pend", dut.i_pend, 1'b0);
    chk1("rstw_d_pend", dut.d_pend, 1'b0);
    chkst("rstw_state", dut.state, ARB_IDLE);
    tick();
    tick();
    chk1("rstw_no_reissue", bus.mem_req, 1'b0);

    // Vector table with the automatic memory model.
    auto_mem = 1'b1;
    for (int r = 0; r < NV; r++) begin
      log_q.delete();
      if (vecs[r].ir) req_i(vecs[r].ia);
      if (vecs[r].dr) req_d(vecs[r].da);
      if (vecs[r].dw) wr_d(vecs[r].wa, vecs[r].wd);
      wait_idle();
      chk_log($sformatf("row%0d", r), int'(vecs[r].n), vecs[r].ex[0], vecs[r].ex[1],
              vecs[r].ex[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
